// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Parity helper is only referenced when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_PRESCALE_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/my_axis_if.sv
// Minimal AXI4-Stream bundle shared between the TX fifo and the serialiser.
interface my_axis_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = (DATA_W + 7) / 8
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport slave  (input  tdata, tkeep, tvalid, tlast, output tready);
    modport master (output tdata, tkeep, tvalid, tlast, input  tready);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Prescale down-counter: reload at each bit start, bit ends when it reaches zero.
module uart_tx_bit_timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  i_load,
    input  logic [PRESCALE_W-1:0] i_reload,
    output logic                  o_bit_done
);

    logic [PRESCALE_W-1:0] r_cnt;

    // Down-counter holds at zero between bits.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt <= {PRESCALE_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_reload;
        end else if (r_cnt != {PRESCALE_W{1'b0}}) begin
            r_cnt <= r_cnt - {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_bit_done = (r_cnt == {PRESCALE_W{1'b0}});

endmodule

// File: rtl/uart_tx_axis.sv
// AXI4-Stream byte to UART serialiser (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
// Bit period comes from Prescale, latched at each accepted byte.
module uart_tx_axis
    import uart_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W,
    parameter int PRESCALE_W = UART_PRESCALE_W
) (
    input  logic                  Clk,
    input  logic                  Rst,
    my_axis_if.slave              s_axis,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  Txd,
    output logic                  StatusBusy
);

    localparam logic [PRESCALE_W-1:0] PRESC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    generate
        if (DATA_W != UART_DATA_W) begin : g_bad_data_w
            $error("uart_tx_axis: only DATA_W = 8 is supported");
        end
    endgenerate

    tx_state_t             r_state;
    tx_state_t             w_state_next;
    logic [DATA_W-1:0]     r_data;
    logic [2:0]            r_idx;
    logic [2:0]            w_idx_next;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] w_presc_in;
    logic [PRESCALE_W-1:0] w_reload;
    logic                  r_txd;
    logic                  w_txd_next;
    logic                  r_busy;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_load;
    logic                  w_bit_done;
    logic                  w_unused;

    assign w_unused      = s_axis.tlast;
    assign s_axis.tready = (r_state == IDLE) && !Rst;
    assign w_accept      = s_axis.tvalid && s_axis.tready;
    // A byte with tkeep[0] low is consumed without producing a frame.
    assign w_start       = w_accept && s_axis.tkeep[0];
    assign w_presc_in    = (Prescale == {PRESCALE_W{1'b0}}) ? PRESC_ONE : Prescale;
    assign w_reload      = w_start ? (w_presc_in - PRESC_ONE) : (r_presc - PRESC_ONE);

    uart_tx_bit_timer #(.PRESCALE_W(PRESCALE_W)) u_timer (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_load     (w_load),
        .i_reload   (w_reload),
        .o_bit_done (w_bit_done)
    );

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, bit index and timer reload decisions.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = START;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_state_next = DATA;
                    w_idx_next   = 3'd0;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = START;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_load = 1'b1;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_state_next = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_done) begin
                    w_state_next = STOP;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = PARITY;
                end
            end
`endif
            STOP: begin
                if (w_bit_done) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = STOP;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, so Txd can be a flop.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            START:   w_txd_next = 1'b0;
            DATA:    w_txd_next = r_data[w_idx_next];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_txd_next = even_parity(r_data);
`endif
            default: w_txd_next = 1'b1;
        endcase
    end

    // Datapath registers: latched byte/prescale, bit index and outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_data  <= {DATA_W{1'b0}};
            r_presc <= PRESC_ONE;
            r_idx   <= 3'd0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            if (w_start) begin
                r_data  <= s_axis.tdata;
                r_presc <= w_presc_in;
            end else begin
                r_data  <= r_data;
                r_presc <= r_presc;
            end
            r_idx  <= w_idx_next;
            r_txd  <= w_txd_next;
            r_busy <= (w_state_next != IDLE);
        end
    end

    assign Txd        = r_txd;
    assign StatusBusy = r_busy;

endmodule

// File: tb/tb_uart_tx_axis.sv
// Directed bench for uart_tx_axis; also covers the UART_TX_PARITY_EN build.
module tb_uart_tx_axis;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] prescale;
    logic        txd;
    logic        busy;
    int          n_total;
    int          n_bad;

    my_axis_if #(.DATA_W(8)) axis_if ();

    uart_tx_axis #(.DATA_W(8), .PRESCALE_W(16)) dut (
        .Clk        (clk),
        .Rst        (rst),
        .s_axis     (axis_if),
        .Prescale   (prescale),
        .Txd        (txd),
        .StatusBusy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Expected line levels for one frame followed by idle-high.
    function automatic logic [127:0] frame_bits(input logic [7:0] d, input int p);
        logic [127:0] v;
        int           pp;
        int           j;
        v  = '1;
        pp = (p < 1) ? 1 : p;
        for (int k = 0; k < NB * pp; k++) begin
            j = k / pp;
            if (j == 0)                  v[k] = 1'b0;
            else if (j <= 8)             v[k] = d[j-1];
            else if (j == 9 && NB == 11) v[k] = ^d;
            else                         v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic send(input logic [7:0] d, input logic keep, input logic [15:0] p, input logic hold);
        logic hs;
        @(negedge clk);
        axis_if.tdata  = d;
        axis_if.tkeep  = keep;
        axis_if.tvalid = 1'b1;
        prescale       = p;
        hs             = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (axis_if.tready) begin
                hs = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("handshake", {127'd0, hs}, 128'd1);
        @(posedge clk);
        #1;
        if (!hold) axis_if.tvalid = 1'b0;
    endtask

    // Samples n+1 cycles starting with the cycle after the handshake edge.
    task automatic capture(input int n, output logic [127:0] tv, output logic [127:0] bv,
                           output logic [127:0] rv);
        tv = '1;
        bv = '0;
        rv = '0;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            tv[k] = txd;
            bv[k] = busy;
            rv[k] = axis_if.tready;
        end
    endtask

    logic [127:0] tv, bv, rv, e;

    initial begin
        n_total        = 0;
        n_bad          = 0;
        rst            = 1'b1;
        prescale       = 16'd4;
        axis_if.tdata  = 8'h00;
        axis_if.tkeep  = 1'b1;
        axis_if.tvalid = 1'b0;
        axis_if.tlast  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_txd",    {127'd0, txd},            128'd1);
        check("rst_busy",   {127'd0, busy},           128'd0);
        check("rst_tready", {127'd0, axis_if.tready}, 128'd0);
        rst = 1'b0;
        #1;
        check("post_rst_tready", {127'd0, axis_if.tready}, 128'd1);

        // 0x55 at P=4; Prescale changed mid-frame must not matter.
        send(8'h55, 1'b1, 16'd4, 1'b0);
        prescale = 16'd7;
        capture(NB * 4, tv, bv, rv);
`ifdef UART_TX_PARITY_EN
        check("f55_txd", tv, 128'h1F00F0F0F0F0 | ~((128'd1 << 45) - 128'd1));
`else
        check("f55_txd", tv, 128'h1F0F0F0F0F0 | ~((128'd1 << 41) - 128'd1));
`endif
        check("f55_busy",  bv, (128'd1 << (NB * 4)) - 128'd1);
        check("f55_ready", rv, 128'd1 << (NB * 4));

        // Back-to-back 0xA5, 0x3C at P=2 with tvalid held high.
        send(8'hA5, 1'b1, 16'd2, 1'b1);
        axis_if.tdata = 8'h3C;
        tv = '1;
        bv = '0;
        rv = '0;
        for (int k = 0; k <= 2 * NB * 2 + 1; k++) begin
            @(negedge clk);
            tv[k] = txd;
            bv[k] = busy;
            rv[k] = axis_if.tready;
            if (k == NB * 2 + 1) axis_if.tvalid = 1'b0;
        end
        e = frame_bits(8'hA5, 2) &
            ((frame_bits(8'h3C, 2) << (NB * 2 + 1)) | ((128'd1 << (NB * 2 + 1)) - 128'd1));
        check("b2b_txd", tv, e);
        e = ((128'd1 << (NB * 2)) - 128'd1) | (((128'd1 << (NB * 2)) - 128'd1) << (NB * 2 + 1));
        check("b2b_busy", bv, e);
        check("b2b_ready", rv, (128'd1 << (NB * 2)) | (128'd1 << (NB * 4 + 1)));

        // tkeep=0 byte is swallowed, next byte framed normally.
        send(8'h11, 1'b0, 16'd2, 1'b0);
        capture(2, tv, bv, rv);
        check("drop_txd",   tv, '1);
        check("drop_busy",  bv, 128'd0);
        check("drop_ready", rv, 128'h7);
        send(8'h22, 1'b1, 16'd2, 1'b0);
        capture(NB * 2, tv, bv, rv);
        check("f22_txd",  tv, frame_bits(8'h22, 2));
        check("f22_busy", bv, (128'd1 << (NB * 2)) - 128'd1);

        // Prescale=0 behaves as 1.
        send(8'hFF, 1'b1, 16'd0, 1'b0);
        capture(NB, tv, bv, rv);
`ifdef UART_TX_PARITY_EN
        check("p0_txd", tv, 128'hDFE | ~((128'd1 << 12) - 128'd1));
`else
        check("p0_txd", tv, 128'h7FE | ~((128'd1 << 11) - 128'd1));
`endif
        check("p0_busy", bv, (128'd1 << NB) - 128'd1);

        // Reset during data bit 3 of 0x0F at P=8.
        send(8'h0F, 1'b1, 16'd8, 1'b0);
        repeat (34) @(negedge clk);
        check("mid_busy", {127'd0, busy}, 128'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_tready", {127'd0, axis_if.tready}, 128'd0);
        @(negedge clk);
        check("mid_rst_txd",  {127'd0, txd},  128'd1);
        check("mid_rst_busy", {127'd0, busy}, 128'd0);
        rst = 1'b0;
        #1;
        check("mid_post_tready", {127'd0, axis_if.tready}, 128'd1);
        send(8'h0F, 1'b1, 16'd8, 1'b0);
        capture(NB * 8, tv, bv, rv);
        check("f0f_txd",  tv, frame_bits(8'h0F, 8));
        check("f0f_busy", bv, (128'd1 << (NB * 8)) - 128'd1);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b1, 16'd3, 1'b0);
        capture(33, tv, bv, rv);
        check("par07_bit",  {127'd0, tv[27]}, 128'd1);
        check("par07_stop", {125'd0, tv[32:30]}, 128'h7);
        check("par07_txd",  tv, frame_bits(8'h07, 3));
        check("par07_busy", bv, (128'd1 << 33) - 128'd1);
        send(8'h03, 1'b1, 16'd3, 1'b0);
        capture(33, tv, bv, rv);
        check("par03_bit", {127'd0, tv[27]}, 128'd0);
        check("par03_txd", tv, frame_bits(8'h03, 3));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_axis.md
# uart_tx_axis

Byte-serial UART transmitter that consumes the AXI4-Stream output of the TX-side `fifo` and drives the `Txd` line. It handles the link end opposite the receiver path: AES ciphertext bytes are buffered in `fifo`, pulled by this block one at a time, and serialised as 8N1 frames. Bit timing comes from a runtime prescale value. An optional parity bit is controlled at compile time.

## Interface
Parameters:
- `DATA_W`, 8: stream data width. Only 8 is supported, enforced by an elaboration-time check.
- `PRESCALE_W`, 16: width of the `Prescale` input.

Ports:
- `Clk`  input  1  single clock. One clock; reset is synchronous and active-high.
- `Rst`  input  1  synchronous, active-high reset.
- `s_axis`  `my_axis_if.slave`  `DATA_W`/`KEEP_W`  byte input. Uses `tdata`, `tkeep[0]`, `tvalid`, `tready`. `tlast` is ignored.
- `Prescale`  input  `PRESCALE_W`  clock cycles per bit. 0 is treated as 1.
- `Txd`  output  1  serial line, idle high.
- `StatusBusy`  output  1  high while a frame is in progress, i.e. the state is not IDLE.

## Operation
States: IDLE, START, DATA, PARITY (only with the macro), STOP.

- **IDLE**
  - `Txd`=1 and `tready`=1.
  - On `tvalid && tready` with `tkeep[0]`=1: latch `tdata` and `Prescale`, then go to START.
  - On `tvalid && tready` with `tkeep[0]`=0: the byte is consumed and discarded. Stay in IDLE, no frame is sent, `tready` stays high.
- **START**: `Txd`=0 for one bit period, then go to DATA.
- **DATA**: `Txd` = latched bit i, LSB first, i=0..7, one bit period each. A 3-bit index counts bits. After bit 7, go to PARITY if enabled, else STOP.
- **PARITY**: `Txd` = XOR of the 8 data bits (even parity) for one bit period, then go to STOP.
- **STOP**: `Txd`=1 for one bit period, then go to IDLE.

Bit timer rules:
- Counter of `PRESCALE_W` bits, loaded with latched Prescale−1 at each bit start.
- The bit ends when the counter reaches 0.
- A latched Prescale of 0 is substituted by 1.

Other rules:
- `Prescale` changes mid-frame do not affect the current frame. The new value takes effect at the next accept.
- `tready` is high only in IDLE and only while `Rst` is low, so there is never a handshake during a frame.
- `tvalid` may drop at any time while `tready` is low without effect.

Reset:
- `Rst` is sampled at a clock edge and forces state IDLE, `Txd`=1, bit counter and index to 0, `StatusBusy`=0.
- `tready`=0 in any cycle where `Rst` is high.
- A frame interrupted by reset is abandoned. No truncated stop bit is generated beyond `Txd` returning high.

## Timing
Let P = max(Prescale,1), and let the handshake occur at edge N.

- `Txd` low during cycles N+1 .. N+P.
- Data bit i during N+1+P(1+i) .. N+P(2+i).
- Stop bit during N+1+9P .. N+10P. With parity, the parity bit occupies the 9P slot and stop moves to 10P..11P.
- Frame length is 10P cycles, or 11P with parity.
- `StatusBusy` is high for exactly those cycles.
- IDLE is re-entered in the cycle after the stop bit, and `tready` is high in that cycle.
- Back-to-back bytes therefore have exactly one idle-high cycle between the stop bit and the next start bit.
- Accept-to-start-bit latency is 1 cycle.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: PARITY state is compiled in and frames are 8E1, 11 bit periods.
- Undefined: the PARITY state and parity XOR are removed and frames are 8N1, 10 bit periods.
- All other timing is identical in both builds.

## Structure
- Package `uart_pkg` holds:
  - `tx_state_t` enum: IDLE, START, DATA, PARITY, STOP.
  - `UART_DATA_W` = 8.
  - `UART_PRESCALE_W` = 16.
- Sub-module `uart_tx_bit_timer`:
  - Inputs: load, reload value.
  - Outputs: `bit_done` pulse.
  - Owns the prescale down-counter.
- The top-level module holds the FSM, shift register and `axis` handshake.

## Test plan
- Prescale=4, single byte 0x55 with `tkeep`=1:
  - `Txd` = 0,1,0,1,0,1,0,1,0,1, each level lasting 4 cycles, 40 cycles total.
  - `tready` low for 40 cycles, then high.
  - `StatusBusy` high for exactly 40 cycles.
- `fifo` preloaded with 0xA5, 0x3C at Prescale=2:
  - Two 20-cycle frames, LSB first.
  - Exactly 1 idle-high cycle between the first stop bit and the second start bit.
  - `fifo` `StatusDepth` goes 2→1→0.
- Bytes 0x11 (`tkeep`=0) then 0x22 (`tkeep`=1):
  - 0x11 is consumed with no `Txd` activity.
  - Only the 0x22 frame appears, and it starts 1 cycle after its own handshake.
- Prescale=0, byte 0xFF:
  - Behaves as P=1: a 10-cycle frame, start low for 1 cycle, then 9 high cycles.
- `Rst` asserted for 1 cycle at data bit 3 of 0x0F, Prescale=8:
  - `Txd`=1 in the following cycle, `StatusBusy`=0.
  - `tready` is 0 during `Rst` and 1 the cycle after.
  - The next byte produces a full, correct frame.
- With `UART_TX_PARITY_EN` defined, byte 0x07 at Prescale=3:
  - Parity bit = 1.
  - Frame is 33 cycles, with the stop bit at cycles 31–33 after the handshake.
  - With byte 0x03 the parity bit = 0.
